// File: rtl/norm_shift_pipe_if.sv
// norm_shift_pipe_if
//   Bundles the input channel (mantissa, exponent, LZC result) and the output
//   channel (normalized mantissa, adjusted exponent, flags) of norm_shift_pipe.
//   Parameters: WIDTH (mantissa width), EXP_W (biased exponent width);
//   CNT_W is derived from WIDTH.
//   Modports: slave  - the normalization stage itself
//             master - the environment (upstream LZC plus downstream consumer)
//   Optional: NORM_LZC_CHECK_EN adds lzc_err_o (sticky LZC consistency error).
interface norm_shift_pipe_if #(
  parameter int WIDTH = 31,
  parameter int EXP_W = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             in_valid_i;
  logic             in_ready_o;
  logic             sign_i;
  logic [WIDTH-1:0] mant_i;
  logic [EXP_W-1:0] exp_i;
  logic [CNT_W-1:0] lzc_cnt_i;
  logic             lzc_empty_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             sign_o;
  logic [WIDTH-1:0] mant_o;
  logic [EXP_W-1:0] exp_o;
  logic             zero_o;
  logic             denorm_o;
`ifdef NORM_LZC_CHECK_EN
  logic             lzc_err_o;
`endif

  modport slave (
    input  in_valid_i, sign_i, mant_i, exp_i, lzc_cnt_i, lzc_empty_i, out_ready_i,
    output in_ready_o, out_valid_o, sign_o, mant_o, exp_o, zero_o, denorm_o
`ifdef NORM_LZC_CHECK_EN
    , output lzc_err_o
`endif
  );

  modport master (
    output in_valid_i, sign_i, mant_i, exp_i, lzc_cnt_i, lzc_empty_i, out_ready_i,
    input  in_ready_o, out_valid_o, sign_o, mant_o, exp_o, zero_o, denorm_o
`ifdef NORM_LZC_CHECK_EN
    , input lzc_err_o
`endif
  );
endinterface

// File: rtl/norm_shift_pipe.sv
// norm_shift_pipe
//   Normalization stage after the leading-zero counter. Stage 1 captures the
//   operand and decides shift amount / new exponent (clamping to subnormal on
//   underflow); stage 2 performs the left shift. 2-cycle latency, 1/cycle
//   throughput, valid/ready on both sides.
//   Ports: clk_i  - clock, rising edge
//          rst_ni - asynchronous active-low reset
//          bus    - norm_shift_pipe_if.slave (input and output channels)
//   Optional: define NORM_LZC_CHECK_EN to add a sticky lzc_err_o flag that
//   reports an LZC count/empty inconsistent with the accepted mantissa.
module norm_shift_pipe #(
  parameter  int WIDTH = 31,
  parameter  int EXP_W = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  norm_shift_pipe_if.slave   bus
);
  localparam int CMP_W = (EXP_W > CNT_W) ? EXP_W : CNT_W;

  logic             s1_valid;
  logic             s1_sign;
  logic [WIDTH-1:0] s1_mant;
  logic [CNT_W-1:0] s1_shamt;
  logic [EXP_W-1:0] s1_exp;
  logic             s1_zero;
  logic             s1_denorm;

  logic             out_valid;
  logic             out_sign;
  logic [WIDTH-1:0] out_mant;
  logic [EXP_W-1:0] out_exp;
  logic             out_zero;
  logic             out_denorm;

  logic s2_ready;
  logic in_ready;
  logic in_fire;

  assign s2_ready = ~out_valid | bus.out_ready_i;
  assign in_ready = ~s1_valid | s2_ready;
  assign in_fire  = bus.in_valid_i & in_ready;

  logic [CMP_W-1:0] exp_ext;
  logic [CMP_W-1:0] cnt_ext;
  logic [CNT_W-1:0] shamt_d;
  logic [EXP_W-1:0] exp_d;
  logic             zero_d;
  logic             denorm_d;

  assign exp_ext = CMP_W'(bus.exp_i);
  assign cnt_ext = CMP_W'(bus.lzc_cnt_i);

  // Underflow: shift only as far as the exponent allows. Exponent 0 has the
  // same effective exponent as 1, hence the exp-1 shift and no shift at 0.
  always_comb begin
    shamt_d  = '0;
    exp_d    = '0;
    zero_d   = 1'b0;
    denorm_d = 1'b0;
    if (bus.lzc_empty_i) begin
      zero_d = 1'b1;
    end else if (exp_ext > cnt_ext) begin
      shamt_d = bus.lzc_cnt_i;
      exp_d   = EXP_W'(exp_ext - cnt_ext);
    end else begin
      denorm_d = 1'b1;
      shamt_d  = (bus.exp_i == '0) ? '0 : CNT_W'(exp_ext - CMP_W'(1));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_mant    <= '0;
      s1_shamt   <= '0;
      s1_exp     <= '0;
      s1_zero    <= 1'b0;
      s1_denorm  <= 1'b0;
      out_valid  <= 1'b0;
      out_sign   <= 1'b0;
      out_mant   <= '0;
      out_exp    <= '0;
      out_zero   <= 1'b0;
      out_denorm <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= bus.in_valid_i;
      end
      if (in_fire) begin
        s1_sign   <= bus.sign_i;
        s1_mant   <= bus.mant_i;
        s1_shamt  <= shamt_d;
        s1_exp    <= exp_d;
        s1_zero   <= zero_d;
        s1_denorm <= denorm_d;
      end
      if (s2_ready) begin
        out_valid <= s1_valid;
      end
      if (s1_valid & s2_ready) begin
        out_sign   <= s1_sign;
        out_mant   <= s1_mant << s1_shamt;
        out_exp    <= s1_exp;
        out_zero   <= s1_zero;
        out_denorm <= s1_denorm;
      end
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.sign_o      = out_sign;
  assign bus.mant_o      = out_mant;
  assign bus.exp_o       = out_exp;
  assign bus.zero_o      = out_zero;
  assign bus.denorm_o    = out_denorm;

`ifdef NORM_LZC_CHECK_EN
  logic [CNT_W-1:0] top_idx;
  logic             chk_bad;
  logic             lzc_err;

  // A correct count leaves exactly the leading one after shifting right so
  // that bit sits at position 0; any higher set bit makes the result > 1.
  always_comb begin
    top_idx = CNT_W'(WIDTH - 1) - bus.lzc_cnt_i;
    chk_bad = 1'b0;
    if (bus.lzc_empty_i) begin
      chk_bad = |bus.mant_i;
    end else if (bus.lzc_cnt_i > CNT_W'(WIDTH - 1)) begin
      chk_bad = 1'b1;
    end else begin
      chk_bad = (bus.mant_i >> top_idx) != WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lzc_err <= 1'b0;
    end else if (in_fire & chk_bad) begin
      lzc_err <= 1'b1;
    end
  end

  assign bus.lzc_err_o = lzc_err;
`endif
endmodule

// File: tb/tb_norm_shift_pipe.sv
module tb_norm_shift_pipe;
  localparam int W = 31;
  localparam int E = 8;
  localparam int C = $clog2(W + 1);

  typedef struct packed {
    logic         sign;
    logic [W-1:0] mant;
    logic [E-1:0] exp;
    logic         zero;
    logic         denorm;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  norm_shift_pipe_if #(.WIDTH(W), .EXP_W(E)) bus ();
  norm_shift_pipe #(.WIDTH(W), .EXP_W(E)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int failures = 0;
  int popped = 0;
  int phase = 0;
  bit tog_en = 1'b0;
  bit prev_stall = 1'b0;
  res_t held;
  res_t cur_exp;
  res_t sb[$];

  function automatic res_t mk(logic s, logic [W-1:0] m, logic [E-1:0] e, logic z, logic d);
    res_t r;
    r.sign = s; r.mant = m; r.exp = e; r.zero = z; r.denorm = d;
    return r;
  endfunction

  function automatic res_t model(logic s, logic [W-1:0] m, logic [E-1:0] e, logic [C-1:0] c, logic emp);
    res_t r;
    int sh;
    sh = 0;
    r.sign = s; r.zero = emp; r.denorm = 1'b0; r.exp = '0;
    if (!emp) begin
      if (int'(e) > int'(c)) begin
        sh = int'(c);
        r.exp = E'(int'(e) - int'(c));
      end else begin
        r.denorm = 1'b1;
        sh = (e == 0) ? 0 : int'(e) - 1;
      end
    end
    r.mant = m << sh;
    return r;
  endfunction

  function automatic res_t get_out();
    return mk(bus.sign_o, bus.mant_o, bus.exp_o, bus.zero_o, bus.denorm_o);
  endfunction

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    res_t o;
    res_t e;
    logic exp_rdy;
    if (rst_n) begin
      o = get_out();
      exp_rdy = !(bus.out_valid_o && !bus.out_ready_i && sb.size() == 2);
      checks++;
      assert (bus.in_ready_o === exp_rdy) else begin
        failures++;
        $error("FAIL in_ready got=%b exp=%b", bus.in_ready_o, exp_rdy);
      end
      if (prev_stall) begin
        checks++;
        assert (o === held) else begin
          failures++;
          $error("FAIL stall_hold got=%h exp=%h", o, held);
        end
      end
      prev_stall = bus.out_valid_o && !bus.out_ready_i;
      held = o;
      if (bus.out_valid_o && bus.out_ready_i) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $error("FAIL unexpected_out got=%h exp=none", o);
        end else begin
          e = sb.pop_front();
          popped++;
          assert (o === e) else begin
            failures++;
            $error("FAIL result got=%h exp=%h", o, e);
          end
        end
      end
      if (bus.in_valid_i && bus.in_ready_o) sb.push_back(cur_exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    phase++;
    if (tog_en) bus.out_ready_i = (phase % 4 == 0) || (phase % 4 == 3);
  endtask

  task automatic send(logic s, logic [W-1:0] m, logic [E-1:0] e, logic [C-1:0] c, logic emp, res_t r);
    int n;
    n = 0;
    bus.sign_i = s; bus.mant_i = m; bus.exp_i = e; bus.lzc_cnt_i = c; bus.lzc_empty_i = emp;
    bus.in_valid_i = 1'b1;
    cur_exp = r;
    forever begin
      @(negedge clk);
      if (bus.in_ready_o || n >= 200) break;
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $error("FAIL accept_timeout got=stalled exp=accepted");
    end
    tick();
    bus.in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL drain_timeout got=%0d exp=0", sb.size());
    end
  endtask

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    int base;
    bus.in_valid_i = 1'b0; bus.sign_i = 1'b0; bus.mant_i = '0; bus.exp_i = '0;
    bus.lzc_cnt_i = '0; bus.lzc_empty_i = 1'b0; bus.out_ready_i = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // 1: reset with both stages full
    bus.out_ready_i = 1'b0;
    send(0, 31'h0000_0100, 40, 22, 0, model(0, 31'h0000_0100, 40, 22, 0));
    send(1, 31'h0000_0400, 60, 20, 0, model(1, 31'h0000_0400, 60, 20, 0));
    tick();
    rst_n = 1'b0;
    sb.delete();
    prev_stall = 1'b0;
    tick();
    bus.out_ready_i = 1'b1;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_mant", 64'(bus.mant_o), 64'd0);
    chk("rst_exp", 64'(bus.exp_o), 64'd0);
    chk("rst_zero", 64'(bus.zero_o), 64'd0);
    chk("rst_denorm", 64'(bus.denorm_o), 64'd0);
    chk("rst_sign", 64'(bus.sign_o), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
`ifdef NORM_LZC_CHECK_EN
    chk("rst_lzc_err", 64'(bus.lzc_err_o), 64'd0);
`endif
    tick();

    // 2: normal normalization, with latency
    send(1, 31'h0000_1000, 100, 18, 0, mk(1, 31'h4000_0000, 82, 0, 0));
    chk("lat_stage1", 64'(bus.out_valid_o), 64'd0);
    tick();
    chk("lat_stage2", 64'(bus.out_valid_o), 64'd1);
    drain();

    // 3: underflow clamps
    send(0, 31'h0000_1000, 5, 18, 0, mk(0, 31'h0001_0000, 0, 0, 1));
    send(0, 31'h0000_1000, 0, 18, 0, mk(0, 31'h0000_1000, 0, 0, 1));
    drain();

    // 4: zero mantissa
    send(0, 31'h0, 77, 31, 1, mk(0, 31'h0, 0, 1, 0));
    drain();

    // 5: 16 back-to-back with out_ready pattern 1,0,0,1
    base = popped;
    phase = 0;
    tog_en = 1'b1;
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      send(k[0], 31'(1) << k, E'(20 + k), C'(30 - k), 0,
           model(k[0], 31'(1) << k, E'(20 + k), C'(30 - k), 0));
    end
    drain();
    tog_en = 1'b0;
    bus.out_ready_i = 1'b1;
    chk("burst_count", 64'(popped - base), 64'd16);
`ifdef NORM_LZC_CHECK_EN
    chk("lzc_err_clean", 64'(bus.lzc_err_o), 64'd0);
`endif

`ifdef NORM_LZC_CHECK_EN
    // 6: sticky LZC consistency error
    send(0, 31'h0000_1000, 50, 17, 0, model(0, 31'h0000_1000, 50, 17, 0));
    chk("lzc_err_set", 64'(bus.lzc_err_o), 64'd1);
    for (int k = 0; k < 10; k++) begin
      send(0, 31'(1) << (k + 4), E'(90), C'(26 - k), 0,
           model(0, 31'(1) << (k + 4), E'(90), C'(26 - k), 0));
    end
    drain();
    chk("lzc_err_sticky", 64'(bus.lzc_err_o), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("lzc_err_clear", 64'(bus.lzc_err_o), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/norm_shift_pipe.md
Name: norm_shift_pipe

Overview:
- Normalization stage directly downstream of the leading-zero counter in the float datapath.
- Consumes an unnormalized mantissa, its biased exponent, and the LZC count/empty flags for that mantissa.
- Left-shifts the mantissa so the MSB is 1 and adjusts the exponent, clamping to subnormal when the exponent would underflow.
- 2-stage valid/ready pipeline; full throughput, backpressure-safe.

Parameters:
WIDTH, 31, mantissa width; must match the LZC stage WIDTH.
EXP_W, 8, biased exponent width, unsigned.
CNT_W, $clog2(WIDTH+1), LZC count width; derived, not to be overridden.

Ports:
clk_i  input  1  clock, all state on rising edge
rst_ni  input  1  asynchronous active-low reset
in_valid_i  input  1  input transaction valid
in_ready_o  output  1  stage can accept input
sign_i  input  1  sign, passed through
mant_i  input  WIDTH  unnormalized mantissa
exp_i  input  EXP_W  biased exponent of mant_i
lzc_cnt_i  input  CNT_W  leading-zero count of mant_i (MODE=1 LZC)
lzc_empty_i  input  1  mant_i is all zeros
out_valid_o  output  1  output transaction valid
out_ready_i  input  1  downstream accepts
sign_o  output  1  registered sign
mant_o  output  WIDTH  normalized mantissa
exp_o  output  EXP_W  adjusted exponent
zero_o  output  1  result is zero
denorm_o  output  1  result is subnormal (exp_o=0, MSB not set)

Behaviour:
- Reset (async assert, sync deassert by the environment): s1_valid, out_valid_o, and all data/flag registers go to 0. in_ready_o=1 whenever reset is released. Asserting reset mid-operation drops in-flight transactions with no output.
- Handshake: transfer occurs when valid&ready are both high on a clock edge. in_valid_i and input data may change freely when in_ready_o=0.
- s2_ready = ~out_valid_o | out_ready_i.
- in_ready_o = ~s1_valid | s2_ready. This is combinational with no input-valid dependency.
- Stage 1 (capture plus decision) registers sign, mant, empty, and the following values:
  - If lzc_empty_i=1: shamt=0, exp_n=0, zero=1, denorm=0.
  - Else if exp_i > lzc_cnt_i (compare zero-extended to max(EXP_W,CNT_W)): shamt=lzc_cnt_i, exp_n=exp_i-lzc_cnt_i, denorm=0.
  - Else (underflow): shamt = (exp_i==0) ? 0 : exp_i-1, exp_n=0, denorm=1. Here exp 0 carries effective exponent 1.
  - shamt is always ≤ lzc_cnt_i ≤ WIDTH-1, so no set bits are ever lost.
- Stage 2 (shift) loads mant_o = s1_mant << s1_shamt, and registers exp_o, sign_o, zero_o, denorm_o.
- Latency: 2 cycles from input acceptance to out_valid_o when unstalled.
- Throughput: 1 transaction/cycle.
- Stall:
  - While out_valid_o=1 and out_ready_i=0, all outputs hold stable.
  - Stage 1 holds when s1_valid and ~s2_ready.
  - Simultaneous accept-in and drain-out in one cycle is legal and loses nothing.
- Ordering: strictly FIFO, with no reordering, duplication, or drop.
- Data registers need not reset if the valid bits do. Outputs must still read 0 after reset until the first transfer.

Optional Feature:
- Macro: NORM_LZC_CHECK_EN.
- Defined:
  - Adds output port lzc_err_o (1 bit, reset 0).
  - On each accepted input, the block checks consistency:
    - lzc_empty_i must equal ~|mant_i.
    - If not empty, mant_i[WIDTH-1-lzc_cnt_i] must be 1, with all higher bits 0.
  - On a mismatch, lzc_err_o sets on the edge after acceptance and stays set (sticky) until reset.
  - The datapath result is unaffected and uses the supplied count.
- Undefined: no lzc_err_o port and no check logic.

Test Plan:
1. Assert rst_ni=0 mid-stream with both stages full, then release. Required: out_valid_o=0, mant_o=0, exp_o=0, zero_o=0, denorm_o=0, in_ready_o=1 on the first cycle after release.
2. Send mant_i=0x0000_1000, lzc_cnt_i=18, exp_i=100, sign_i=1, with out_ready_i=1. Required: 2 cycles later mant_o=0x4000_0000, exp_o=82, sign_o=1, denorm_o=0, zero_o=0.
3. Send the same mantissa with exp_i=5. Required: mant_o=0x0001_0000, exp_o=0, denorm_o=1. Also send exp_i=0. Required: mant_o=0x0000_1000, exp_o=0, denorm_o=1.
4. Send mant_i=0, lzc_empty_i=1, exp_i=77. Required: zero_o=1, mant_o=0, exp_o=0, denorm_o=0.
5. Send 16 back-to-back transactions (exp_i=20+k, mant_i=1<<k, lzc_cnt_i=30-k) while toggling out_ready_i with pattern 1,0,0,1,... Required: in_ready_o falls only when both stages are full and out_ready_i=0; outputs stay stable during stalls; all 16 results arrive in order with no loss or duplication.
6. With NORM_LZC_CHECK_EN defined, send mant_i=0x0000_1000 with lzc_cnt_i=17. Required: lzc_err_o=1 one cycle after acceptance and still 1 after 10 further valid transactions, cleared only by rst_ni.
